// File: rtl/button_conditioner_pkg.sv
// Shared types and timing constants for the pushbutton conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 50 MHz defaults: 10 ms debounce, 500 ms hold, 100 ms repeat
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_HOLD_CYCLES     = 25000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 5000000;

  // Counter width wide enough for the largest timing constant plus a spare bit
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces an active-low pushbutton and produces press/release/auto-repeat strobes.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_n,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  // The sample that enters a wait state is the first of the run, so the
  // wait state finishes when its counter reaches DEBOUNCE_CYCLES-2.
  localparam logic [CW-1:0] DB_DONE = CW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam bit DB_SINGLE = (DEBOUNCE_CYCLES == 1);

  logic          btn_s;
  btn_state_e    state;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_inc_c;
  logic [CW-1:0] hold_target_c;
  logic          repeating;
  logic          press_evt_c;
  logic          release_evt_c;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_n),
    .q     (btn_s)
  );

  // Debounce run completes on this edge
  assign press_evt_c   = !btn_s && ((state == S_IDLE && DB_SINGLE) ||
                                    (state == S_PRESS_WAIT && db_cnt == DB_DONE));
  assign release_evt_c =  btn_s && ((state == S_PRESSED && DB_SINGLE) ||
                                    (state == S_RELEASE_WAIT && db_cnt == DB_DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      db_cnt        <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= press_evt_c;
      release_pulse <= release_evt_c;
      if (press_evt_c) begin
        level       <= 1'b1;
        press_count <= press_count + 8'd1;
      end
      if (release_evt_c) level <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!btn_s) begin
            state  <= DB_SINGLE ? S_PRESSED : S_PRESS_WAIT;
            db_cnt <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (btn_s) begin
            state  <= S_IDLE;
            db_cnt <= '0;
          end else if (press_evt_c) begin
            state  <= S_PRESSED;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + ONE;
          end
        end
        S_PRESSED: begin
          if (btn_s) begin
            state  <= DB_SINGLE ? S_IDLE : S_RELEASE_WAIT;
            db_cnt <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (!btn_s) begin
            state  <= S_PRESSED;
            db_cnt <= '0;
          end else if (release_evt_c) begin
            state  <= S_IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + ONE;
          end
        end
        default: begin
          state  <= S_IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Hold timer restarts at each repeat so it never needs to exceed the largest period
  assign hold_inc_c    = hold_cnt + ONE;
  assign hold_target_c = repeating ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt     <= '0;
      repeating    <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (press_evt_c || release_evt_c || !level) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (hold_inc_c == hold_target_c) begin
        hold_cnt     <= '0;
        repeating    <= 1'b1;
        repeat_pulse <= REPEAT_EN;
      end else begin
        hold_cnt <= hold_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus random stimulus against a run-length/offset model of the conditioner.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_n;
  logic       level;
  logic       press_pulse;
  logic       release_pulse;
  logic       repeat_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_meta, m_q, m_run_val;
  int         m_run_len, m_hold;
  bit         m_level, m_press, m_release, m_repeat;
  logic [7:0] m_count;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .REPEAT_EN       (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button_n      (button_n),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_meta = 1'b1; m_q = 1'b1;
    m_run_val = 1'b1; m_run_len = 0; m_hold = 0;
    m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
    m_count = 8'd0;
  endtask

  // One clock edge: the debouncer sees the button value from two edges earlier
  task automatic model_step();
    bit samp;
    samp   = m_q;
    m_q    = m_meta;
    m_meta = button_n;
    if (samp == m_run_val) m_run_len++;
    else begin
      m_run_val = samp;
      m_run_len = 1;
    end
    m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
    if (!m_level && !m_run_val && m_run_len >= D) begin
      m_level = 1'b1; m_press = 1'b1; m_count = m_count + 8'd1; m_hold = 0;
    end else if (m_level && m_run_val && m_run_len >= D) begin
      m_level = 1'b0; m_release = 1'b1; m_hold = 0;
    end else if (m_level) begin
      m_hold++;
      m_repeat = (m_hold >= H) && ((m_hold - H) % R == 0);
    end
  endtask

  task automatic check_all();
    check1("level", level, m_level);
    check1("press_pulse", press_pulse, m_press);
    check1("release_pulse", release_pulse, m_release);
    check1("repeat_pulse", repeat_pulse, m_repeat);
    check1("press_count", press_count, m_count);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
    check_all();
  endtask

  task automatic press_once();
    button_n = 1'b0;
    repeat (7) tick();
    button_n = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int nrep, npulse, nrel, len;
    bit exp_rep;

    // Reset held with the button pressed
    reset = 1'b0; button_n = 1'b0;
    model_reset();
    repeat (5) begin
      tick();
      check1("rst_outputs", {level, press_pulse, release_pulse, repeat_pulse}, 0);
      check1("rst_count", press_count, 0);
    end

    // Idle released, then a clean press
    reset = 1'b1; button_n = 1'b1;
    repeat (8) tick();
    button_n = 1'b0;
    repeat (5) tick();
    check1("press_early", level, 0);
    tick();
    check1("press_level", level, 1);
    check1("press_pulse_6th", press_pulse, 1);
    check1("press_count_1", press_count, 1);

    // Hold: repeats at offsets 10,13,...,28 from the press edge
    nrep = 0;
    for (int off = 1; off <= 30; off++) begin
      tick();
      nrep += int'(repeat_pulse);
      exp_rep = (off >= 10) && (off <= 28) && ((off - 10) % 3 == 0);
      check1("repeat_offset", repeat_pulse, exp_rep);
    end
    check1("repeat_total", nrep, 7);

    // Release six edges after button_n rises
    button_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check1("release_timing", release_pulse, (i == 6) ? 1 : 0);
    end
    check1("release_level", level, 0);
    repeat (4) tick();

    // Bounce never reaches a full debounce run
    npulse = 0;
    repeat (5) begin
      button_n = 1'b0;
      repeat (3) begin
        tick();
        npulse += int'(press_pulse | release_pulse | repeat_pulse);
      end
      button_n = 1'b1;
      tick();
      npulse += int'(press_pulse | release_pulse | repeat_pulse);
    end
    repeat (6) begin
      tick();
      npulse += int'(press_pulse | release_pulse | repeat_pulse);
    end
    check1("bounce_level", level, 0);
    check1("bounce_pulses", npulse, 0);

    // Random run lengths around the debounce threshold
    repeat (80) begin
      button_n = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 16));
      repeat (len) tick();
    end

    // Counter wrap from a fresh reset
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    button_n = 1'b1;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    repeat (256) press_once();
    check1("wrap_256", press_count, 0);
    press_once();
    check1("wrap_257", press_count, 1);

    // Reset while pressed: no release strobe, then a fresh press
    button_n = 1'b0;
    repeat (8) tick();
    check1("mid_level_before", level, 1);
    reset = 1'b0;
    model_reset();
    #1;
    check1("mid_rst_level", level, 0);
    check1("mid_rst_count", press_count, 0);
    nrel = 0;
    repeat (4) begin
      tick();
      nrel += int'(release_pulse);
    end
    check1("mid_rst_no_release", nrel, 0);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check1("mid_repress_pulse", press_pulse, (i == 6) ? 1 : 0);
    end
    check1("mid_repress_count", press_count, 1);
    button_n = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
